// File: rtl/spi_regfile_rw_pkg.sv
// Shared types and constants for the SPI register file.
// Frame layout: write bit, address field, data field.
package spi_regfile_rw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic CMD_WRITE = 1'b1;

    function automatic int frame_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with programmable reset level.
// Rise/fall pulses come from the last stage and its delayed copy.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= {STAGES{RST_VAL}};
            q_d <= RST_VAL;
        end else begin
            sr  <= {sr[STAGES-2:0], d};
            q_d <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = sr[STAGES-1] & ~q_d;
    assign fall = ~sr[STAGES-1] & q_d;

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 slave owning a bank of configuration registers.
// Write frames commit on cs rise; read frames stream reg data on sdo.
module spi_regfile_rw #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       sdi,
    input  logic                       cs,
    output logic                       sdo,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    import spi_regfile_rw_pkg::*;

    localparam int FW = frame_w(ADDR_W, DATA_W);
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] C_FULL = CW'(FW);
    localparam logic [CW-1:0] C_SAT  = CW'(FW + 1);
    localparam logic [CW-1:0] C_HDR  = CW'(1 + ADDR_W);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk(clk), .rst_n(rst_n), .d(sdi),
        .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    state_t                 state;
    logic [FW-1:0]          frame;
    logic [CW-1:0]          cnt;
    logic [DATA_W-1:0]      rd_sh;
    logic                   rd_act;
    logic                   rd_oor;
    logic                   armed;
    logic [SYNC_STAGES:0]   flush;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    logic [FW-1:0]          frame_nxt;
    logic [ADDR_W-1:0]      hdr_addr;
    logic                   hdr_oor;
    logic [DATA_W-1:0]      rd_val;
    logic [ADDR_W-1:0]      f_addr;
    logic                   accept;
    logic                   rd_good;

    assign frame_nxt = {frame[FW-2:0], sdi_s};
    assign hdr_addr  = frame_nxt[ADDR_W-1:0];
    assign hdr_oor   = int'(hdr_addr) >= NUM_REGS;
    assign f_addr    = frame[FW-2 -: ADDR_W];

    assign accept  = (cnt == C_FULL) && (frame[FW-1] == CMD_WRITE)
                   && (int'(f_addr) < NUM_REGS);
    assign rd_good = (cnt == C_FULL) && (frame[FW-1] != CMD_WRITE)
                   && !rd_oor;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (hdr_addr == ADDR_W'(i)) rd_val = regs[i];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

    // armed stays low until cs is seen high after the synchroniser flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame     <= '0;
            cnt       <= '0;
            rd_sh     <= '0;
            rd_act    <= 1'b0;
            rd_oor    <= 1'b0;
            armed     <= 1'b0;
            flush     <= '0;
            sdo       <= 1'b0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && cs_s) armed <= 1'b1;

            unique case (state)
                IDLE: begin
                    sdo <= 1'b0;
                    if (armed && cs_fall) begin
                        state  <= SHIFT;
                        frame  <= '0;
                        cnt    <= '0;
                        rd_act <= 1'b0;
                        rd_oor <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise) begin
                            frame <= frame_nxt;
                            if (cnt != C_SAT) cnt <= cnt + CW'(1);
                            if (cnt + CW'(1) == C_HDR &&
                                frame_nxt[ADDR_W] != CMD_WRITE) begin
                                rd_sh  <= rd_val;
                                rd_act <= 1'b1;
                                rd_oor <= hdr_oor;
                            end
                        end
                        if (sclk_fall && rd_act) begin
                            sdo   <= rd_sh[DATA_W-1];
                            rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    sdo   <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (f_addr == ADDR_W'(i)) begin
                                regs[i]      <= frame[DATA_W-1:0];
                                wr_strobe[i] <= 1'b1;
                            end
                        end
                    end else if (!rd_good) begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Scoreboard bench for spi_regfile_rw driving SPI frames.
module tb_spi_regfile_rw;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int NR = 5;
    localparam int SS = 2;
    localparam int H  = 6;

    logic clk = 1'b0;
    logic rst_n, sclk, sdi, cs;
    logic sdo, frame_err;
    logic [NR*DW-1:0] regs_out;
    logic [NR-1:0]    wr_strobe;

    always #5 clk = ~clk;

    spi_regfile_rw #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs(cs),
        .sdo(sdo), .regs_out(regs_out), .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [NR-1:0] strb;
        logic          err;
    } ev_t;

    ev_t evq[$];
    logic [DW-1:0] model [NR];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n && (wr_strobe != '0 || frame_err)) begin
            if (evq.size() == 0) begin
                chk("unexpected_event", {wr_strobe, frame_err}, '0);
            end else begin
                e = evq.pop_front();
                chk("event", {wr_strobe, frame_err}, e);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] word, input int nbits,
                        input int rst_at, output logic [31:0] samp);
        samp = '0;
        cs = 1'b0;
        clks(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                clks(3);
                rst_n = 1'b1;
                for (int k = 0; k < NR; k++) model[k] = '0;
            end
            sdi = word[nbits-1-i];
            clks(H);
            samp = {samp[30:0], sdo};
            sclk = 1'b1;
            clks(H);
            sclk = 1'b0;
        end
        clks(H);
        cs  = 1'b1;
        sdi = 1'b0;
    endtask

    task automatic frame(input logic [31:0] word, input int nbits,
                         input int rst_at, input int gap);
        logic [31:0]   samp;
        logic [DW-1:0] rexp;
        logic [AW-1:0] a;
        logic          isrd;
        ev_t           e;
        isrd = 1'b0;
        rexp = '0;
        a    = word[14:8];
        if (rst_at < 0) begin
            if (nbits != 16) begin
                e.strb = '0; e.err = 1'b1; evq.push_back(e);
            end else if (word[15]) begin
                if (int'(a) < NR) begin
                    model[int'(a)] = word[7:0];
                    e.strb = NR'(1) << a; e.err = 1'b0;
                end else begin
                    e.strb = '0; e.err = 1'b1;
                end
                evq.push_back(e);
            end else begin
                isrd = 1'b1;
                if (int'(a) < NR) begin
                    rexp = model[int'(a)];
                end else begin
                    e.strb = '0; e.err = 1'b1; evq.push_back(e);
                end
            end
        end
        xfer(word, nbits, rst_at, samp);
        clks(gap);
        if (rst_at < 0) begin
            if (isrd) begin
                chk("sdo_hdr", samp[15:8], 8'h00);
                chk("rd_data", samp[7:0], rexp);
            end else begin
                chk("sdo_wr", samp, 32'h0);
            end
        end
        chk("regs", regs_out, model_flat());
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; sdi = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        clks(4);
        chk("rst_regs", regs_out, '0);
        chk("rst_strb", wr_strobe, '0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_sdo", sdo, 1'b0);
        rst_n = 1'b1;
        clks(10);

        frame(32'h81A5, 16, -1, 12);
        chk("reg1", regs_out[15:8], 8'hA5);

        frame(32'h833C, 16, -1, 12);
        frame(32'h0300, 16, -1, 12);
        chk("reg3", regs_out[31:24], 8'h3C);

        frame(32'h85FF, 16, -1, 12);
        frame(32'h0700, 16, -1, 12);

        frame(32'h82AB >> 6, 10, -1, 12);
        frame(32'h82AB0, 20, -1, 12);
        chk("reg2", regs_out[23:16], 8'h00);

        frame(32'h8477, 16, 9, 12);
        chk("mid_rst", regs_out, '0);
        frame(32'h8477, 16, -1, 12);
        chk("reg4", regs_out[39:32], 8'h77);

        frame(32'h8011, 16, -1, SS + 3);
        frame(32'h8122, 16, -1, SS + 3);
        chk("reg0", regs_out[7:0], 8'h11);
        chk("reg1b", regs_out[15:8], 8'h22);

        clks(20);
        chk("drain", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
